// File: rtl/sd_arb_pkg.sv
// Purpose: shared types and helpers for the SD sector-port arbiter.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
package sd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        XFER,
        RELEASE
    } arb_state_t;

    typedef enum logic {
        RD,
        WR
    } arb_dir_t;

    localparam int NREQ_MAX = 8;

    // Ceiling log2 for elaboration-time index widths.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sd_arb_rr_pick.sv
// Purpose: combinational round-robin picker; first set req bit searching ptr+1 upward with wrap.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when to act on the pick.
// Ports: req (request vector), ptr (last served index), gnt (one-hot pick), idx (pick index),
//        valid (any request present).
module sd_arb_rr_pick
    import sd_arb_pkg::*;
#(
    parameter int NREQ = 5,
    parameter int IW   = 3
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            valid
);

    always_comb begin : pick
        int cand;
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = 0;
        // Offsets 1..NREQ: the last served client is considered last.
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(ptr) + k) % NREQ;
            if (!valid && req[cand]) begin
                valid     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/sd_request_arbiter.sv
// Purpose: shares one SD sector port among NREQ clients, round-robin, one command in flight.
// Latency: request to sd_rd/sd_wr 1 cycle; ack/done registered 1 cycle after sd_busy/sd_done.
// Backpressure: command held until sd_busy; requests wait while another client owns the port.
// Optional watchdog: define SD_ARB_TIMEOUT_EN to abort a command after TIMEOUT_CYC cycles.
// Ports: clk/reset_n (sync active-low); req_rd/req_wr/req_lba from clients; req_ack/req_done/
//        req_byte_strobe/grant back to clients; arb_busy/arb_error status; sd_* to/from controller.
module sd_request_arbiter
    import sd_arb_pkg::*;
#(
    parameter int          NREQ        = 5,
    parameter logic [23:0] TIMEOUT_CYC = 24'd4000000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req_rd,
    input  logic [NREQ-1:0]      req_wr,
    input  logic [NREQ*32-1:0]   req_lba,
    output logic [NREQ-1:0]      req_ack,
    output logic [NREQ-1:0]      req_done,
    output logic [NREQ-1:0]      req_byte_strobe,
    output logic [NREQ-1:0]      grant,
    output logic                 arb_busy,
    output logic                 arb_error,
    output logic [31:0]          sd_lba,
    output logic                 sd_rd,
    output logic                 sd_wr,
    input  logic                 sd_busy,
    input  logic                 sd_done,
    input  logic                 sd_rd_byte_strobe
);

    localparam int IW = (clog2(NREQ) < 1) ? 1 : clog2(NREQ);

    arb_state_t      state_q, state_n;
    arb_dir_t        dir_q, dir_n;
    logic [NREQ-1:0] grant_q, grant_n;
    logic [IW-1:0]   owner_q, owner_n;
    logic [IW-1:0]   ptr_q, ptr_n;
    logic [31:0]     lba_q, lba_n;
    logic            cmd_q, cmd_n;
    logic [NREQ-1:0] ack_q, ack_n;
    logic [NREQ-1:0] done_q, done_n;
    logic            busy_q, busy_n;
    logic            err_q, err_n;
    logic            timeout;

    logic [NREQ-1:0] pick_gnt;
    logic [IW-1:0]   pick_idx;
    logic            pick_vld;
    logic [31:0]     pick_lba;
    logic            pick_rd;

    sd_arb_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req   (req_rd | req_wr),
        .ptr   (ptr_q),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_vld)
    );

    // One-hot mux of the picked client's address.
    always_comb begin
        pick_lba = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_gnt[i]) begin
                pick_lba = req_lba[32*i +: 32];
            end
        end
    end

    // A client asserting both read and write gets the read first.
    assign pick_rd = |(pick_gnt & req_rd);

`ifdef SD_ARB_TIMEOUT_EN
    logic [23:0] cnt_q, cnt_n;

    assign timeout = ((state_q == ISSUE) || (state_q == XFER)) &&
                     (cnt_q == (TIMEOUT_CYC - 24'd1));

    always_comb begin
        cnt_n = cnt_q;
        if (state_q == IDLE) begin
            cnt_n = '0;
        end else if ((state_q == ISSUE) || (state_q == XFER)) begin
            cnt_n = cnt_q + 24'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_n;
        end
    end
`else
    // Limit only matters with the watchdog built in.
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = ^TIMEOUT_CYC;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_n = state_q;
        dir_n   = dir_q;
        grant_n = grant_q;
        owner_n = owner_q;
        ptr_n   = ptr_q;
        lba_n   = lba_q;
        cmd_n   = cmd_q;
        busy_n  = busy_q;
        ack_n   = '0;
        done_n  = '0;
        err_n   = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_n = pick_gnt;
                    owner_n = pick_idx;
                    lba_n   = pick_lba;
                    dir_n   = pick_rd ? RD : WR;
                    cmd_n   = 1'b1;
                    busy_n  = 1'b1;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                // sd_done without sd_busy is a stray pulse and is ignored here.
                if (sd_busy) begin
                    cmd_n = 1'b0;
                    ack_n = grant_q;
                    if (sd_done) begin
                        done_n  = grant_q;
                        state_n = RELEASE;
                    end else begin
                        state_n = XFER;
                    end
                end
            end
            XFER: begin
                if (sd_done) begin
                    done_n  = grant_q;
                    state_n = RELEASE;
                end
            end
            RELEASE: begin
                grant_n = '0;
                busy_n  = 1'b0;
                ptr_n   = owner_q;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Watchdog abort overrides whatever the controller is doing this cycle.
        if (timeout) begin
            cmd_n   = 1'b0;
            done_n  = grant_q;
            err_n   = 1'b1;
            state_n = RELEASE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            dir_q   <= RD;
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= IW'(NREQ - 1);
            lba_q   <= '0;
            cmd_q   <= 1'b0;
            ack_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            dir_q   <= dir_n;
            grant_q <= grant_n;
            owner_q <= owner_n;
            ptr_q   <= ptr_n;
            lba_q   <= lba_n;
            cmd_q   <= cmd_n;
            ack_q   <= ack_n;
            done_q  <= done_n;
            busy_q  <= busy_n;
            err_q   <= err_n;
        end
    end

    assign grant     = grant_q;
    assign req_ack   = ack_q;
    assign req_done  = done_q;
    assign arb_busy  = busy_q;
    assign arb_error = err_q;
    assign sd_lba    = lba_q;
    assign sd_rd     = cmd_q && (dir_q == RD);
    assign sd_wr     = cmd_q && (dir_q == WR);

    // Byte strobes reach only the owner, with no register in the path.
    assign req_byte_strobe = (state_q == XFER) ? (grant_q & {NREQ{sd_rd_byte_strobe}}) : '0;

endmodule
